// File: rtl/pcie_ss_axis_demux.sv
// 1:N PCIe SS AXI-S packet demux: steers whole packets to one of NUM_CH outputs by a first-beat header field.
// Optional macro PCIE_SS_AXIS_DEMUX_DEFAULT_ROUTE_EN: deliver out-of-range packets to DEFAULT_CH instead of dropping.
module pcie_ss_axis_demux #(
    parameter int NUM_CH      = 2,
    parameter int PL_DEPTH    = 1,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int SEL_LSB     = 0,
    parameter int SEL_FIELD_W = 8,
    parameter int DEFAULT_CH  = 0,
    parameter int CNT_W       = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,

    input  logic                                    sink_tvalid_i,
    output logic                                    sink_tready_o,
    input  logic [TDATA_WIDTH-1:0]                  sink_tdata_i,
    input  logic [TDATA_WIDTH/8-1:0]                sink_tkeep_i,
    input  logic                                    sink_tlast_i,
    input  logic [TUSER_WIDTH-1:0]                  sink_tuser_vendor_i,

    output logic [NUM_CH-1:0]                       source_tvalid_o,
    input  logic [NUM_CH-1:0]                       source_tready_i,
    output logic [NUM_CH-1:0][TDATA_WIDTH-1:0]      source_tdata_o,
    output logic [NUM_CH-1:0][TDATA_WIDTH/8-1:0]    source_tkeep_o,
    output logic [NUM_CH-1:0]                       source_tlast_o,
    output logic [NUM_CH-1:0][TUSER_WIDTH-1:0]      source_tuser_vendor_o,

    output logic [CNT_W-1:0]                        drop_cnt_o
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int BEAT_W = TUSER_WIDTH + 1 + KEEP_W + TDATA_WIDTH;
    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int LAST_BIT = TDATA_WIDTH + KEEP_W;
    localparam logic [SEL_W-1:0] DEF_IDX = SEL_W'(DEFAULT_CH);

`ifdef PCIE_SS_AXIS_DEMUX_DEFAULT_ROUTE_EN
    localparam bit ROUTE_OOR = 1'b1;
`else
    localparam bit ROUTE_OOR = 1'b0;
`endif

    typedef enum logic {SOP, BODY} state_e;

    // Skid pipeline: element 0 is the sink, element PL_DEPTH is the internal "in" stream
    logic [PL_DEPTH:0]  pl_valid;
    logic [PL_DEPTH:0]  pl_ready;
    logic [BEAT_W-1:0]  pl_data [PL_DEPTH+1];

    assign pl_valid[0]   = sink_tvalid_i;
    assign pl_data[0]    = {sink_tuser_vendor_i, sink_tlast_i, sink_tkeep_i, sink_tdata_i};
    assign sink_tready_o = pl_ready[0];

    for (genvar i = 0; i < PL_DEPTH; i++) begin : g_pl
        logic              main_v_q;
        logic              skid_v_q;
        logic [BEAT_W-1:0] main_q;
        logic [BEAT_W-1:0] skid_q;
        logic              main_load;

        // Upstream ready depends only on skid occupancy, so it is a pure register output
        assign pl_ready[i]     = ~skid_v_q;
        assign pl_valid[i+1]   = main_v_q;
        assign pl_data[i+1]    = main_q;
        assign main_load       = pl_ready[i+1] | ~main_v_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                main_v_q <= 1'b0;
                skid_v_q <= 1'b0;
            end else if (main_load) begin
                main_v_q <= skid_v_q | pl_valid[i];
                skid_v_q <= 1'b0;
            end else if (pl_valid[i] && !skid_v_q) begin
                skid_v_q <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (main_load) begin
                main_q <= skid_v_q ? skid_q : pl_data[i];
            end else if (pl_valid[i] && !skid_v_q) begin
                skid_q <= pl_data[i];
            end
        end
    end

    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_beat;
    logic              in_last;

    assign in_valid           = pl_valid[PL_DEPTH];
    assign in_beat            = pl_data[PL_DEPTH];
    assign in_last            = in_beat[LAST_BIT];
    assign pl_ready[PL_DEPTH] = in_ready;

    logic [SEL_FIELD_W-1:0] ch_raw;
    logic                   oor;

    assign ch_raw = in_beat[SEL_LSB +: SEL_FIELD_W];
    assign oor    = 32'(ch_raw) >= NUM_CH;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   route_q, route_d;
    logic               route_drop_q, route_drop_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0]  out_valid_q;
    logic [BEAT_W-1:0]  out_beat_q [NUM_CH];
    logic [NUM_CH-1:0]  ordy;
    logic [NUM_CH-1:0]  wr;
    logic [SEL_W-1:0]   dest_idx;
    logic               dest_drop;
    logic               accept;

    assign ordy = ~out_valid_q | source_tready_i;

    // Decode on SOP, otherwise follow the latched route until tlast is accepted
    always_comb begin
        state_d      = state_q;
        route_d      = route_q;
        route_drop_d = route_drop_q;
        drop_cnt_d   = drop_cnt_q;
        wr           = '0;
        dest_idx     = route_q;
        dest_drop    = route_drop_q;

        if (state_q == SOP) begin
            dest_idx  = oor ? DEF_IDX : ch_raw[SEL_W-1:0];
            dest_drop = oor & ~ROUTE_OOR;
        end

        in_ready = dest_drop | ordy[dest_idx];
        accept   = in_valid & in_ready;

        if (accept) begin
            if (!dest_drop) begin
                wr[dest_idx] = 1'b1;
            end
            if (state_q == SOP) begin
                if (oor && drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
                if (!in_last) begin
                    state_d      = BODY;
                    route_d      = dest_idx;
                    route_drop_d = dest_drop;
                end
            end else if (in_last) begin
                state_d = SOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SOP;
            route_q      <= '0;
            route_drop_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            route_q      <= route_d;
            route_drop_q <= route_drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr[c]) begin
                    out_valid_q[c] <= 1'b1;
                end else if (ordy[c]) begin
                    out_valid_q[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr[c]) begin
                out_beat_q[c] <= in_beat;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign source_tdata_o[c]        = out_beat_q[c][TDATA_WIDTH-1:0];
        assign source_tkeep_o[c]        = out_beat_q[c][TDATA_WIDTH +: KEEP_W];
        assign source_tlast_o[c]        = out_beat_q[c][LAST_BIT];
        assign source_tuser_vendor_o[c] = out_beat_q[c][LAST_BIT+1 +: TUSER_WIDTH];
    end

    assign source_tvalid_o = out_valid_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_pcie_ss_axis_demux.sv
// Scoreboard bench for pcie_ss_axis_demux: driver pushes expected beats per channel, a negedge monitor pops and compares.
module tb_pcie_ss_axis_demux;

    localparam int NUM_CH     = 4;
    localparam int PL_DEPTH   = 1;
    localparam int TDW        = 64;
    localparam int TUW        = 4;
    localparam int KW         = TDW / 8;
    localparam int CNT_W      = 4;
    localparam int DEFAULT_CH = 3;
    localparam int BW         = TUW + 1 + KW + TDW;

    typedef logic [BW-1:0] beat_t;

    logic                          clk;
    logic                          rst_n;
    logic                          sinkValid;
    logic                          sink_tready_o;
    logic [TDW-1:0]                sinkData;
    logic [KW-1:0]                 sinkKeep;
    logic                          sinkLast;
    logic [TUW-1:0]                sinkUser;
    logic [NUM_CH-1:0]             source_tvalid_o;
    logic [NUM_CH-1:0]             srcReady;
    logic [NUM_CH-1:0][TDW-1:0]    source_tdata_o;
    logic [NUM_CH-1:0][KW-1:0]     source_tkeep_o;
    logic [NUM_CH-1:0]             source_tlast_o;
    logic [NUM_CH-1:0][TUW-1:0]    source_tuser_vendor_o;
    logic [CNT_W-1:0]              drop_cnt_o;

    pcie_ss_axis_demux #(
        .NUM_CH(NUM_CH), .PL_DEPTH(PL_DEPTH), .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW),
        .SEL_LSB(0), .SEL_FIELD_W(8), .DEFAULT_CH(DEFAULT_CH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_tvalid_i(sinkValid), .sink_tready_o(sink_tready_o),
        .sink_tdata_i(sinkData), .sink_tkeep_i(sinkKeep),
        .sink_tlast_i(sinkLast), .sink_tuser_vendor_i(sinkUser),
        .source_tvalid_o(source_tvalid_o), .source_tready_i(srcReady),
        .source_tdata_o(source_tdata_o), .source_tkeep_o(source_tkeep_o),
        .source_tlast_o(source_tlast_o), .source_tuser_vendor_o(source_tuser_vendor_o),
        .drop_cnt_o(drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    beat_t expQ [NUM_CH][$];
    int    hsCyc[$];
    int    hsCh[$];
    bit    hsLast[$];
    bit    monitorOn = 1'b0;
    int    checks = 0;
    int    passes = 0;
    int    presentCycle = 0;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every handshake on any source is matched against that channel's expected queue
    always @(negedge clk) begin
        if (rst_n && monitorOn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (source_tvalid_o[c] && srcReady[c]) begin
                    beat_t act;
                    act = {source_tuser_vendor_o[c], source_tlast_o[c], source_tkeep_o[c], source_tdata_o[c]};
                    hsCyc.push_back(cycle);
                    hsCh.push_back(c);
                    hsLast.push_back(source_tlast_o[c]);
                    if (expQ[c].size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected beat ch%0d: got %0h expected none", c, act);
                    end else begin
                        checkOutput($sformatf("ch%0d beat", c), act, expQ[c].pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input beat_t b, output int waited);
        bit rdy;
        bit done;
        sinkValid = 1'b1;
        {sinkUser, sinkLast, sinkKeep, sinkData} = b;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            rdy = sink_tready_o;
            @(posedge clk);
            #1;
            waited++;
            if (rdy) done = 1'b1;
            else if (waited >= 200) begin
                checks++;
                $display("[TB] FAIL sink accept timeout: got tready=0 for %0d cycles expected accept", waited);
                done = 1'b1;
            end
        end
    endtask

    task automatic sendPacket(input int field, input int nbeats, input logic [7:0] tag, output int cyclesUsed);
        int    ch;
        int    w;
        beat_t b;
        ch = field;
        if (field >= NUM_CH) begin
`ifdef PCIE_SS_AXIS_DEMUX_DEFAULT_ROUTE_EN
            ch = DEFAULT_CH;
`else
            ch = -1;
`endif
        end
        cyclesUsed = 0;
        presentCycle = cycle;
        for (int i = 0; i < nbeats; i++) begin
            b = {4'(tag + 8'(i)), (i == nbeats - 1), (i == nbeats - 1) ? 8'h0F : 8'hFF,
                 tag, 8'(i), 32'h1234_5678, 8'hA5, 8'(field)};
            if (ch >= 0) expQ[ch].push_back(b);
            applyStimulus(b, w);
            cyclesUsed += w;
        end
    endtask

    task automatic clearHs();
        hsCyc.delete();
        hsCh.delete();
        hsLast.delete();
    endtask

    initial begin
        int  cyc;
        int  ch1LastCyc;
        int  ch0Cyc;
        int  span;
        bit  stalled;
        beat_t b;

        rst_n = 1'b0;
        sinkValid = 1'b0;
        {sinkUser, sinkLast, sinkKeep, sinkData} = '0;
        srcReady = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset tvalid", source_tvalid_o, 0);
        checkOutput("reset drop_cnt", drop_cnt_o, 0);
        checkOutput("reset sink_tready", sink_tready_o, 1);
        monitorOn = 1'b1;

        // Single-beat packet to ch2 with latency check
        @(posedge clk); #1;
        clearHs();
        sendPacket(2, 1, 8'h11, cyc);
        sinkValid = 1'b0;
        repeat (6) @(posedge clk); #1;
        checkOutput("single beat count", hsCyc.size(), 1);
        checkOutput("single beat channel", (hsCh.size() > 0) ? hsCh[0] : -1, 2);
        checkOutput("single beat latency", (hsCyc.size() > 0) ? hsCyc[0] - presentCycle : -1, PL_DEPTH + 1);

        // Backpressured ch1 packet with a ch0 packet queued behind it
        clearHs();
        stalled = 1'b0;
        fork
            begin
                sendPacket(1, 3, 8'h22, cyc);
                sendPacket(0, 1, 8'h33, cyc);
                sinkValid = 1'b0;
            end
            begin
                int n = 0;
                while (!source_tvalid_o[1] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) begin
                    checks++;
                    $display("[TB] FAIL ch1 first beat timeout: got no tvalid expected tvalid");
                end
                @(posedge clk); #1;
                srcReady[1] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!sink_tready_o) stalled = 1'b1;
                end
                @(posedge clk); #1;
                srcReady[1] = 1'b1;
            end
        join
        repeat (10) @(posedge clk); #1;
        checkOutput("sink stalled by ch1", stalled, 1);
        ch1LastCyc = -1;
        ch0Cyc = -1;
        for (int i = 0; i < hsCyc.size(); i++) begin
            if (hsCh[i] == 1 && hsLast[i]) ch1LastCyc = hsCyc[i];
            if (hsCh[i] == 0 && ch0Cyc < 0) ch0Cyc = hsCyc[i];
        end
        checkOutput("ch0 after ch1 tlast", (ch1LastCyc >= 0) && (ch0Cyc > ch1LastCyc), 1);

        // Back-to-back packets must produce 7 consecutive output beats
        clearHs();
        sendPacket(0, 2, 8'h44, cyc);
        sendPacket(3, 1, 8'h55, cyc);
        sendPacket(0, 4, 8'h66, cyc);
        sinkValid = 1'b0;
        repeat (10) @(posedge clk); #1;
        checkOutput("b2b beat count", hsCyc.size(), 7);
        span = (hsCyc.size() == 7) ? hsCyc[6] - hsCyc[0] : -1;
        checkOutput("b2b no bubble span", span, 6);

        // Out-of-range packet, then saturation of drop_cnt
        clearHs();
        sendPacket(7, 4, 8'h77, cyc);
        sinkValid = 1'b0;
        checkOutput("oor sink cycles", cyc, 4);
        repeat (6) @(posedge clk); #1;
        checkOutput("drop_cnt after oor", drop_cnt_o, 1);
`ifdef PCIE_SS_AXIS_DEMUX_DEFAULT_ROUTE_EN
        checkOutput("oor output beats", hsCyc.size(), 4);
`else
        checkOutput("oor output beats", hsCyc.size(), 0);
`endif
        for (int p = 0; p < 16; p++) sendPacket(7, 1, 8'h80 + 8'(p), cyc);
        sinkValid = 1'b0;
        repeat (6) @(posedge clk); #1;
        checkOutput("drop_cnt saturated", drop_cnt_o, 4'hF);

        // Reset in the middle of a ch2 packet
        monitorOn = 1'b0;
        b = {4'h1, 1'b0, 8'hFF, 8'hC0, 8'h00, 32'h0, 8'hA5, 8'h02};
        applyStimulus(b, cyc);
        b = {4'h2, 1'b0, 8'hFF, 8'hC0, 8'h01, 32'h0, 8'hA5, 8'h02};
        applyStimulus(b, cyc);
        rst_n = 1'b0;
        sinkValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid-pkt reset tvalid", source_tvalid_o, 0);
        checkOutput("mid-pkt reset drop_cnt", drop_cnt_o, 0);
        checkOutput("mid-pkt reset sink_tready", sink_tready_o, 1);
        for (int c = 0; c < NUM_CH; c++) expQ[c].delete();
        clearHs();
        monitorOn = 1'b1;
        @(posedge clk); #1;
        sendPacket(1, 1, 8'h88, cyc);
        sinkValid = 1'b0;
        repeat (6) @(posedge clk); #1;
        checkOutput("post-reset route ch1", (hsCh.size() == 1) ? hsCh[0] : -1, 1);

        // Field 9: dropped by default, routed to DEFAULT_CH when the feature is built in
        clearHs();
        sendPacket(9, 2, 8'h99, cyc);
        sinkValid = 1'b0;
        repeat (6) @(posedge clk); #1;
        checkOutput("field9 drop_cnt", drop_cnt_o, 1);
`ifdef PCIE_SS_AXIS_DEMUX_DEFAULT_ROUTE_EN
        checkOutput("field9 beats on default ch", hsCyc.size(), 2);
`else
        checkOutput("field9 beats on default ch", hsCyc.size(), 0);
`endif

        for (int c = 0; c < NUM_CH; c++)
            checkOutput($sformatf("ch%0d queue drained", c), expQ[c].size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
